alu_exec: RTL and testbench
===========================

# alu_exec

Parametrised execute unit for the x86-subset core, the successor to the single-cycle opcode ALU, clocked on the phase-5 clock. Accepts one decoded opcode per start pulse and latches operands. Computes the real result, stack-pointer update and arithmetic flags over one or two execute cycles. Reports completion with a one-cycle done pulse to the sequencer.

## Interface
- DATA_W, 32: operand/result width; multiple of 8, ≥ 8.
- ADDR_W, 8: stack-pointer width.
- STEP, DATA_W/8: byte adjustment applied to esp by push/pop/call/ret.

- clock_5  in  1  execute-phase clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- ope  in  8  opcode byte.
- immidiate_data  in  DATA_W  immediate / call displacement.
- reg_a  in  DATA_W  first operand (source reg, popped memory data, or current eip for call).
- reg_b  in  DATA_W  second operand (add/sub).
- esp_in  in  ADDR_W  current stack pointer.
- busy  out  1  high from the cycle after start acceptance until done clears.
- done  out  1  one-cycle completion pulse.
- alu_result_bus  out  DATA_W  registered result.
- esp_out  out  ADDR_W  registered new stack pointer.
- esp_we  out  1  valid with done; esp_out must be written back.
- flags  out  3  {SF, ZF, CF}, registered.
- illegal  out  1  valid with done; opcode not supported.

## Operation
- Reset is asynchronous on reset_n low, with no clock needed. All outputs go to 0, state goes to IDLE and latched operands are cleared.
- FSM states: IDLE, EXEC, EXEC2, DONE.
  - IDLE→EXEC when start=1. ope, immidiate_data, reg_a, reg_b and esp_in are latched on that edge.
  - EXEC→EXEC2 when latched ope=0xe8; otherwise EXEC→DONE.
  - EXEC2→DONE.
  - DONE→IDLE unconditionally.
- start outside IDLE is ignored. It is not queued.
- Opcode behaviour (E = latched esp, A = reg_a, B = reg_b, I = imm):
  - 0x55 push: esp_out=E−STEP, esp_we=1, result=A.
  - 0x89 mov: result=A, esp_we=0.
  - 0xb8 mov imm: result=I, esp_we=0.
  - 0x5d pop: esp_out=E+STEP, esp_we=1, result=A.
  - 0xc3 ret: as pop; result is the new eip.
  - 0xe8 call: EXEC computes esp_out=E−STEP. EXEC2 computes result=A+I (target eip). esp_we=1.
  - 0x01 add: result=A+B, flags updated.
  - 0x29 sub: result=A−B, flags updated.
  - Any other value: illegal=1. result, esp_out and flags hold their previous values. esp_we=0.
- Arithmetic widths:
  - esp arithmetic is modulo 2^ADDR_W and wraps silently.
  - Data arithmetic is modulo 2^DATA_W.
  - CF is the carry-out for add and the borrow for sub (A<B unsigned).
  - ZF = result==0.
  - SF = result[DATA_W−1].
- flags change only on add/sub and hold otherwise.
- alu_result_bus and esp_out hold their value until the next completing operation.
- esp_we and illegal are meaningful only while done=1. They are 0 in all other cycles.

## Timing
- Cycle 0: start=1 in IDLE, sampled at the rising edge.
- Cycles 1..: busy=1.
- Single-cycle ops: outputs are registered at the end of cycle 1, and done=1 in cycle 2.
- call: outputs are registered at the end of cycle 2, and done=1 in cycle 3.
- busy stays high through the done cycle. It falls with done.
- Next start is accepted at the earliest on the edge following the done cycle. Issue interval is 3 cycles, or 4 for call.
- reset_n low mid-operation:
  - Aborts immediately.
  - done is not produced for the aborted op.
  - Outputs return to 0.
  - After release, the first start is accepted on the first clock_5 edge with reset_n high.
- Inputs only need to be stable at the start-sampling edge. Changes to them while busy have no effect.

## Test plan
- Reset: assert reset_n=0 asynchronously mid-EXEC of an add. Required: busy, done, result, flags and esp_out are 0 immediately, and no done pulse follows release.
- Push/pop with DATA_W=32, esp_in=0x10, ope=0x55. Required: done in cycle 2, esp_out=0x0C, esp_we=1. Then ope=0x5d with esp_in=0x0C and reg_a=0xDEADBEEF. Required: esp_out=0x10, result=0xDEADBEEF.
- Wrap-around: esp_in=0x02 with push. Required: esp_out=0xFE. Also esp_in=0xFE with pop. Required: esp_out=0x02.
- Call: ope=0xe8, reg_a=0x100, imm=0x20, esp_in=0x40. Required: busy for cycles 1–3, done only in cycle 3, result=0x120, esp_out=0x3C. A start pulse in cycle 2 is ignored.
- Flags: sub with A=5, B=5. Required: ZF=1, CF=0, SF=0. Then sub with A=0, B=1. Required: result=0xFFFFFFFF, CF=1, SF=1, ZF=0. Then add with A=0xFFFFFFFF, B=1. Required: result=0, CF=1, ZF=1. Then a mov. Required: flags unchanged.
- Illegal: ope=0x90 after a completed mov imm (I=0x77). Required: done=1 with illegal=1 and esp_we=0, while result stays 0x77 and flags stay unchanged.

Source files
------------

// File: rtl/alu_exec_if.sv
// alu_exec_if: request/response bundle between the sequencer and the
// execute unit.
//   master: sequencer side, drives start/ope/operands/esp_in and observes
//           busy/done/results.
//   slave : execute unit side.
// DATA_W and ADDR_W must match the alu_exec instance they connect to.
interface alu_exec_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8
);
  logic              start;
  logic [7:0]        ope;
  logic [DATA_W-1:0] immidiate_data;
  logic [DATA_W-1:0] reg_a;
  logic [DATA_W-1:0] reg_b;
  logic [ADDR_W-1:0] esp_in;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] alu_result_bus;
  logic [ADDR_W-1:0] esp_out;
  logic              esp_we;
  logic [2:0]        flags;
  logic              illegal;

  modport master (
    output start, ope, immidiate_data, reg_a, reg_b, esp_in,
    input  busy, done, alu_result_bus, esp_out, esp_we, flags, illegal
  );

  modport slave (
    input  start, ope, immidiate_data, reg_a, reg_b, esp_in,
    output busy, done, alu_result_bus, esp_out, esp_we, flags, illegal
  );
endinterface

// File: rtl/alu_exec.sv
// alu_exec: multi-cycle execute unit for the x86-subset core.
// Accepts one decoded opcode per start pulse in IDLE, latches operands,
// computes result / stack-pointer update / {SF,ZF,CF} over one execute
// cycle (two for call) and signals completion with a one-cycle done pulse.
// Ports:
//   clock_5 : execute-phase clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : alu_exec_if.slave (start, ope, immidiate_data, reg_a, reg_b,
//             esp_in in; busy, done, alu_result_bus, esp_out, esp_we,
//             flags, illegal out; all outputs registered)
module alu_exec #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned STEP   = DATA_W / 8
) (
  input logic        clock_5,
  input logic        reset_n,
  alu_exec_if.slave  bus
);

  localparam logic [7:0] OP_PUSH    = 8'h55;
  localparam logic [7:0] OP_MOV     = 8'h89;
  localparam logic [7:0] OP_MOV_IMM = 8'hb8;
  localparam logic [7:0] OP_POP     = 8'h5d;
  localparam logic [7:0] OP_RET     = 8'hc3;
  localparam logic [7:0] OP_CALL    = 8'he8;
  localparam logic [7:0] OP_ADD     = 8'h01;
  localparam logic [7:0] OP_SUB     = 8'h29;

  localparam logic [ADDR_W-1:0] ESP_STEP = ADDR_W'(STEP);

  typedef enum logic [1:0] {IDLE, EXEC, EXEC2, DONE} state_t;

  state_t            state_q, state_d;
  logic [7:0]        ope_q, ope_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [ADDR_W-1:0] esp_q, esp_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [ADDR_W-1:0] esp_out_q, esp_out_d;
  logic              esp_we_q, esp_we_d;
  logic [2:0]        flags_q, flags_d;
  logic              illegal_q, illegal_d;

  logic [DATA_W:0]   sum_ext;
  logic [DATA_W-1:0] diff;

  assign sum_ext = {1'b0, a_q} + {1'b0, b_q};
  assign diff    = a_q - b_q;

  always_comb begin
    state_d   = state_q;
    ope_d     = ope_q;
    imm_d     = imm_q;
    a_d       = a_q;
    b_d       = b_q;
    esp_d     = esp_q;
    result_d  = result_q;
    esp_out_d = esp_out_q;
    flags_d   = flags_q;
    esp_we_d  = 1'b0;
    illegal_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          ope_d   = bus.ope;
          imm_d   = bus.immidiate_data;
          a_d     = bus.reg_a;
          b_d     = bus.reg_b;
          esp_d   = bus.esp_in;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = DONE;
        case (ope_q)
          OP_PUSH: begin
            result_d  = a_q;
            esp_out_d = esp_q - ESP_STEP;
            esp_we_d  = 1'b1;
          end
          OP_POP, OP_RET: begin
            result_d  = a_q;
            esp_out_d = esp_q + ESP_STEP;
            esp_we_d  = 1'b1;
          end
          OP_MOV:     result_d = a_q;
          OP_MOV_IMM: result_d = imm_q;
          OP_CALL: begin
            // New esp is parked in the latched esp so esp_out only moves
            // together with the result when the call completes.
            esp_d   = esp_q - ESP_STEP;
            state_d = EXEC2;
          end
          OP_ADD: begin
            result_d = sum_ext[DATA_W-1:0];
            flags_d  = {sum_ext[DATA_W-1], (sum_ext[DATA_W-1:0] == '0), sum_ext[DATA_W]};
          end
          OP_SUB: begin
            result_d = diff;
            flags_d  = {diff[DATA_W-1], (diff == '0), (a_q < b_q)};
          end
          default: illegal_d = 1'b1;
        endcase
      end
      EXEC2: begin
        result_d  = a_q + imm_q;
        esp_out_d = esp_q;
        esp_we_d  = 1'b1;
        state_d   = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock_5 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ope_q     <= '0;
      imm_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      esp_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      esp_out_q <= '0;
      esp_we_q  <= 1'b0;
      flags_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ope_q     <= ope_d;
      imm_q     <= imm_d;
      a_q       <= a_d;
      b_q       <= b_d;
      esp_q     <= esp_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      esp_out_q <= esp_out_d;
      esp_we_q  <= esp_we_d;
      flags_q   <= flags_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.alu_result_bus = result_q;
  assign bus.esp_out        = esp_out_q;
  assign bus.esp_we         = esp_we_q;
  assign bus.flags          = flags_q;
  assign bus.illegal        = illegal_q;

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed self-checking bench for alu_exec (DATA_W=32,
// ADDR_W=8). Expected results are queued when an operation is issued and
// compared when done is observed.
module tb_alu_exec;

  logic clock_5 = 1'b0;
  logic reset_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clock_5 = ~clock_5;

  alu_exec_if #(.DATA_W(32), .ADDR_W(8)) bus ();

  alu_exec #(.DATA_W(32), .ADDR_W(8), .STEP(4)) dut (
    .clock_5 (clock_5),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic [7:0]  esp;
    logic        we;
    logic [2:0]  flags;
    logic        ill;
    int          lat;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Issue one op at a negedge (cycle 0); returns at the negedge of the
  // cycle following done, ready for the next issue.
  task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic [7:0] esp, input bit pulse_c2,
                        input exp_t e);
    int   n;
    bit   seen;
    exp_t got;
    bus.start          = 1'b1;
    bus.ope            = op;
    bus.reg_a          = a;
    bus.reg_b          = b;
    bus.immidiate_data = imm;
    bus.esp_in         = esp;
    sb.push_back(e);
    @(negedge clock_5);
    // Inputs scrambled while busy must not matter.
    bus.start          = 1'b0;
    bus.ope            = 8'h01;
    bus.reg_a          = $urandom;
    bus.reg_b          = $urandom;
    bus.immidiate_data = $urandom;
    bus.esp_in         = 8'($urandom);
    n    = 1;
    seen = 1'b0;
    while (!seen && n <= 6) begin
      chk({e.tag, "_busy"}, 32'(bus.busy), 32'd1);
      if (bus.done) seen = 1'b1;
      else begin
        @(negedge clock_5);
        n++;
        bus.start = (pulse_c2 && n == 2);
        if (pulse_c2 && n == 2) bus.ope = 8'h55;
      end
    end
    bus.start = 1'b0;
    chk({e.tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({e.tag, "_latency"}, 32'(n), 32'(e.lat));
    chk({e.tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      got = sb.pop_front();
      chk({got.tag, "_result"}, bus.alu_result_bus, got.res);
      chk({got.tag, "_esp_out"}, 32'(bus.esp_out), 32'(got.esp));
      chk({got.tag, "_esp_we"}, 32'(bus.esp_we), 32'(got.we));
      chk({got.tag, "_flags"}, 32'(bus.flags), 32'(got.flags));
      chk({got.tag, "_illegal"}, 32'(bus.illegal), 32'(got.ill));
    end
    @(negedge clock_5);
    chk({e.tag, "_done_falls"}, 32'(bus.done), 32'd0);
    chk({e.tag, "_busy_falls"}, 32'(bus.busy), 32'd0);
    chk({e.tag, "_we_after"}, 32'(bus.esp_we), 32'd0);
    chk({e.tag, "_ill_after"}, 32'(bus.illegal), 32'd0);
  endtask

  function automatic exp_t mk(input string tag, input logic [31:0] res, input logic [7:0] esp,
                              input logic we, input logic [2:0] flags, input logic ill,
                              input int lat);
    exp_t e;
    e.tag = tag; e.res = res; e.esp = esp; e.we = we; e.flags = flags; e.ill = ill; e.lat = lat;
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    bus.start = 1'b0; bus.ope = '0; bus.reg_a = '0; bus.reg_b = '0;
    bus.immidiate_data = '0; bus.esp_in = '0;
    #3;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_result", bus.alu_result_bus, 32'd0);
    chk("rst_esp_out", 32'(bus.esp_out), 32'd0);
    chk("rst_flags", 32'(bus.flags), 32'd0);
    repeat (2) @(negedge clock_5);
    reset_n = 1'b1;
    @(negedge clock_5);

    // Establish non-zero outputs, then abort an add mid-EXEC.
    run_op(8'h55, 32'h11111111, 32'h0, 32'h0, 8'h10, 1'b0,
           mk("pre_push", 32'h11111111, 8'h0c, 1'b1, 3'b000, 1'b0, 2));
    run_op(8'h29, 32'h0, 32'h1, 32'h0, 8'h00, 1'b0,
           mk("pre_sub", 32'hffffffff, 8'h0c, 1'b0, 3'b101, 1'b0, 2));
    bus.start = 1'b1; bus.ope = 8'h01; bus.reg_a = 32'h5; bus.reg_b = 32'h7;
    @(negedge clock_5);
    bus.start = 1'b0;
    chk("abort_busy_before", 32'(bus.busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_result", bus.alu_result_bus, 32'd0);
    chk("abort_flags", 32'(bus.flags), 32'd0);
    chk("abort_esp_out", 32'(bus.esp_out), 32'd0);
    @(negedge clock_5);
    reset_n = 1'b1;
    dones = 0;
    repeat (5) begin
      @(negedge clock_5);
      if (bus.done) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);

    run_op(8'h55, 32'h12345678, 32'h0, 32'h0, 8'h10, 1'b0,
           mk("push", 32'h12345678, 8'h0c, 1'b1, 3'b000, 1'b0, 2));
    run_op(8'h5d, 32'hdeadbeef, 32'h0, 32'h0, 8'h0c, 1'b0,
           mk("pop", 32'hdeadbeef, 8'h10, 1'b1, 3'b000, 1'b0, 2));
    run_op(8'h55, 32'h1, 32'h0, 32'h0, 8'h02, 1'b0,
           mk("push_wrap", 32'h1, 8'hfe, 1'b1, 3'b000, 1'b0, 2));
    run_op(8'h5d, 32'h2, 32'h0, 32'h0, 8'hfe, 1'b0,
           mk("pop_wrap", 32'h2, 8'h02, 1'b1, 3'b000, 1'b0, 2));
    run_op(8'he8, 32'h100, 32'h0, 32'h20, 8'h40, 1'b1,
           mk("call", 32'h120, 8'h3c, 1'b1, 3'b000, 1'b0, 3));
    run_op(8'h29, 32'h5, 32'h5, 32'h0, 8'h00, 1'b0,
           mk("sub_eq", 32'h0, 8'h3c, 1'b0, 3'b010, 1'b0, 2));
    run_op(8'h29, 32'h0, 32'h1, 32'h0, 8'h00, 1'b0,
           mk("sub_borrow", 32'hffffffff, 8'h3c, 1'b0, 3'b101, 1'b0, 2));
    run_op(8'h01, 32'hffffffff, 32'h1, 32'h0, 8'h00, 1'b0,
           mk("add_carry", 32'h0, 8'h3c, 1'b0, 3'b011, 1'b0, 2));
    run_op(8'h89, 32'hcafef00d, 32'h0, 32'h0, 8'h99, 1'b0,
           mk("mov", 32'hcafef00d, 8'h3c, 1'b0, 3'b011, 1'b0, 2));
    run_op(8'hb8, 32'h0, 32'h0, 32'h77, 8'h99, 1'b0,
           mk("mov_imm", 32'h77, 8'h3c, 1'b0, 3'b011, 1'b0, 2));
    run_op(8'h90, 32'h55555555, 32'h1, 32'h33, 8'h11, 1'b0,
           mk("illegal", 32'h77, 8'h3c, 1'b0, 3'b011, 1'b1, 2));
    run_op(8'hc3, 32'h200, 32'h0, 32'h0, 8'h3c, 1'b0,
           mk("ret", 32'h200, 8'h40, 1'b1, 3'b011, 1'b0, 2));
    run_op(8'h01, 32'h7fffffff, 32'h1, 32'h0, 8'h00, 1'b0,
           mk("add_sign", 32'h80000000, 8'h40, 1'b0, 3'b100, 1'b0, 2));

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
